// File: rtl/usb_pkg.sv
// Shared USB definitions: data PIDs, data-type encoding, CRC16 constants and
// the transmit FSM state type.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        DT_DATA0 = 2'b00,
        DT_DATA1 = 2'b01,
        DT_DATA2 = 2'b10,
        DT_MDATA = 2'b11
    } data_type_e;

    // States name the byte the output register loads next.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_CRC_LO = 3'd2,
        ST_CRC_HI = 3'd3
    } tx_state_e;

    function automatic logic [3:0] pid_of(input logic [1:0] dt);
        logic [3:0] p;
        case (dt)
            DT_DATA0: p = PID_DATA0;
            DT_DATA1: p = PID_DATA1;
            DT_DATA2: p = PID_DATA2;
            default:  p = PID_MDATA;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational USB CRC16 step over one byte, bits taken LSB-first.
// Shared by the transmit builder and the receive CRC check.
module usb_crc16
    import usb_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_c[15] ^ i_data[i]) w_c = {w_c[14:0], 1'b0} ^ CRC16_POLY;
            else                     w_c = {w_c[14:0], 1'b0};
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/usb_data_tx.sv
// USB data-packet builder: frames a payload stream as PID + payload + CRC16
// and drives it byte-wise into the ULPI transmit port.
module usb_data_tx
    import usb_pkg::*;
#(
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] data_type,
    input  logic       zlp,
    input  logic [7:0] s_tdata,
    input  logic       s_tlast,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] tx_tdata,
    output logic       tx_tlast,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic       busy,
    output logic       done,
    output logic       truncated,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = $clog2(MAX_PKT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT - 1);

    tx_state_e        r_state;
    logic [15:0]      r_crc;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_tx_tdata;
    logic             r_tx_tvalid;
    logic             r_tx_tlast;
    logic             r_busy;
    logic             r_done;
    logic             r_trunc;
    logic             r_trunc_pend;

    logic             w_load;
    logic             w_s_fire;
    logic [3:0]       w_pid;
    logic [15:0]      w_crc_next;

    // Both ports are AXI-stream: a byte moves on a cycle where valid & ready,
    // valid never drops and data never changes until that happens. The output
    // register can take a new byte whenever it is empty or being drained.
    assign w_load    = ~r_tx_tvalid | tx_tready;
    assign s_tready  = w_load & (r_state == ST_DATA);
    assign w_s_fire  = s_tready & s_tvalid;
    assign w_pid     = pid_of(data_type);

    assign tx_tdata  = r_tx_tdata;
    assign tx_tvalid = r_tx_tvalid;
    assign tx_tlast  = r_tx_tlast;
    assign busy      = r_busy;
    assign done      = r_done;
    assign truncated = r_trunc;
    assign dbg_state = r_state;

    usb_crc16 u_crc16 (
        .i_crc  (r_crc),
        .i_data (s_tdata),
        .o_crc  (w_crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_crc        <= CRC16_INIT;
            r_count      <= '0;
            r_tx_tdata   <= 8'h00;
            r_tx_tvalid  <= 1'b0;
            r_tx_tlast   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_trunc      <= 1'b0;
            r_trunc_pend <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_trunc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The output stage is always empty here, so the PID loads at once.
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_crc        <= CRC16_INIT;
                        r_count      <= '0;
                        r_trunc_pend <= 1'b0;
                        r_tx_tdata   <= {~w_pid, w_pid};
                        r_tx_tvalid  <= 1'b1;
                        r_tx_tlast   <= 1'b0;
                        r_state      <= zlp ? ST_CRC_LO : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_s_fire) begin
                        r_tx_tdata  <= s_tdata;
                        r_tx_tvalid <= 1'b1;
                        r_crc       <= w_crc_next;
                        r_count     <= r_count + CNT_W'(1);
                        if (s_tlast || r_count == LAST_IDX) begin
                            r_trunc_pend <= ~s_tlast;
                            r_state      <= ST_CRC_LO;
                        end
                    end else if (w_load) begin
                        r_tx_tvalid <= 1'b0;
                    end
                end
                ST_CRC_LO: begin
                    if (w_load) begin
                        r_tx_tdata  <= bitrev8(~r_crc[15:8]);
                        r_tx_tvalid <= 1'b1;
                        r_state     <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    // Loads the final byte, then waits here until it is accepted.
                    if (r_tx_tvalid && r_tx_tlast) begin
                        if (tx_tready) begin
                            r_tx_tvalid <= 1'b0;
                            r_tx_tlast  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_trunc     <= r_trunc_pend;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_load) begin
                        r_tx_tdata  <= bitrev8(~r_crc[7:0]);
                        r_tx_tvalid <= 1'b1;
                        r_tx_tlast  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_data_tx.sv
// Bench for usb_data_tx: reflected-CRC packet model with an expected-byte
// queue checked on every accepted output beat, plus directed literal checks.
module tb_usb_data_tx;

    localparam int MAX_PKT = 8;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] data_type;
    logic       zlp;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] tx_tdata;
    logic       tx_tlast;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy;
    logic       done;
    logic       truncated;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q[$];
    logic [8:0] exp_q[$];
    logic       exp_tr_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] cap2[$];
    bit gap_mode = 0;
    bit rdy_rand = 0;
    bit flush    = 0;
    bit src_fire;
    bit done_due = 0;
    bit exp_tr   = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    usb_data_tx #(.MAX_PKT(MAX_PKT)) dut (
        .clk(clk), .rst(rst), .start(start), .data_type(data_type), .zlp(zlp),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .busy(busy), .done(done), .truncated(truncated), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // USB CRC16 in its reflected form: poly A001, init FFFF, output inverted.
    function automatic logic [15:0] model_crc(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        foreach (b[k]) for (int i = 0; i < 8; i++)
            c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction

    // Receive-side check over payload+CRC; returns the register in MSB-first form.
    function automatic logic [15:0] rx_residual(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        logic [15:0] r;
        foreach (b[k]) for (int i = 0; i < 8; i++)
            c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return r;
    endfunction

    // Payload source: holds a byte until taken, optional random gaps between bytes.
    initial begin
        s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        forever begin
            @(negedge clk);
            src_fire = s_tvalid & s_tready;
            @(posedge clk); #1;
            if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
            if (flush) begin src_q.delete(); flush = 0; end
            if (src_q.size() > 0 && (!gap_mode || (s_tvalid && !src_fire) || $urandom_range(0, 2) != 0)) begin
                s_tvalid = 1;
                {s_tlast, s_tdata} = src_q[0];
            end else begin
                s_tvalid = 0;
            end
        end
    end

    initial begin
        tx_tready = 0;
        forever begin
            @(posedge clk); #1;
            tx_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: every accepted output byte against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); exp_tr_q.delete();
            done_due = 0; prev_stall = 0;
        end else begin
            if (done_due) begin
                chk("done_pulse", done, 1);
                chk("truncated_flag", truncated, exp_tr);
                chk("busy_after_done", busy, 0);
                done_due = 0;
            end else if (done || truncated) begin
                chk("spurious_done", {done, truncated}, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", tx_tvalid, 1);
                chk("stall_data", tx_tdata, prev_data);
                chk("stall_last", tx_tlast, prev_last);
            end
            if (tx_tvalid && !tx_tready) chk("s_tready_while_full", s_tready, 0);
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", {tx_tlast, tx_tdata});
                end else begin
                    chk("tx_byte", {tx_tlast, tx_tdata}, exp_q.pop_front());
                    cap_q.push_back(tx_tdata);
                    if (tx_tlast) begin
                        done_due = 1;
                        exp_tr = (exp_tr_q.size() > 0) ? exp_tr_q.pop_front() : 1'b0;
                    end
                end
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            prev_last  = tx_tlast;
        end
    end

    // Call at a negedge. Queues payload and model bytes, pulses start.
    task automatic send_pkt(input logic [1:0] dt, input bit z, input bq_t pl);
        logic [7:0]  pid_tab[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
        bq_t         sent;
        logic [15:0] crc;
        int          n;
        if (!z) foreach (pl[k]) src_q.push_back({(k == pl.size() - 1), pl[k]});
        n = z ? 0 : ((pl.size() < MAX_PKT) ? pl.size() : MAX_PKT);
        exp_q.push_back({1'b0, pid_tab[dt]});
        for (int k = 0; k < n; k++) begin
            sent.push_back(pl[k]);
            exp_q.push_back({1'b0, pl[k]});
        end
        crc = model_crc(sent);
        exp_q.push_back({1'b0, crc[7:0]});
        exp_q.push_back({1'b1, crc[15:8]});
        exp_tr_q.push_back(!z && pl.size() > MAX_PKT);
        @(posedge clk); #1;
        start = 1; data_type = dt; zlp = z;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("tvalid_after_start", tx_tvalid, 1);
        chk("pid_byte", tx_tdata, pid_tab[dt]);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 300) begin @(negedge clk); n++; end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
        end
    endtask

    task automatic wait_last_fire();
        int n = 0;
        @(negedge clk);
        while (!(tx_tvalid && tx_tready && tx_tlast) && n < 300) begin @(negedge clk); n++; end
        if (!(tx_tvalid && tx_tready && tx_tlast)) begin
            checks++; errors++;
            $display("FAIL last_byte_timeout: got no tlast expected tlast within 300 cycles");
        end
    endtask

    task automatic clear_cap();
        @(posedge clk); #1;
        cap_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400us");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        bq_t pl;
        bq_t tail;
        rst = 1; start = 0; data_type = 0; zlp = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_tvalid", tx_tvalid, 0);
        chk("rst_tlast", tx_tlast, 0);
        chk("rst_tdata", tx_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done, truncated}, 0);
        chk("rst_s_tready", s_tready, 0);

        // Model pinned to the published CRC-16/USB check value.
        chk("model_crc_check", model_crc(ascii), 16'hB4C8);

        // 1: DATA1 zero-length packet
        clear_cap();
        send_pkt(2'b01, 1'b1, pl);
        wait_done("zlp");
        chk("zlp_len", cap_q.size(), 3);
        chk("zlp_bytes", {cap_q[0], cap_q[1], cap_q[2]}, 24'h4B0000);

        // 2: DATA0 with four payload bytes
        clear_cap();
        pl = '{8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt(2'b00, 1'b0, pl);
        wait_done("data0");
        chk("data0_len", cap_q.size(), 7);
        chk("data0_head", {cap_q[0], cap_q[1], cap_q[2], cap_q[3]}, 32'hC3000102);
        chk("data0_byte4", cap_q[4], 8'h03);
        tail = cap_q[1:$];
        chk("data0_residual", rx_residual(tail), 16'h800D);
        cap2 = cap_q;

        // 3: 12-byte stream truncated at MAX_PKT
        clear_cap();
        pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
               8'h18, 8'h19, 8'h1A, 8'h1B};
        send_pkt(2'b00, 1'b0, pl);
        wait_done("trunc");
        chk("trunc_len", cap_q.size(), 11);
        chk("trunc_left", src_q.size(), 4);
        chk("trunc_head", (src_q.size() > 0) ? src_q[0][7:0] : 8'hXX, 8'h18);
        chk("trunc_held_valid", s_tvalid, 1);
        chk("trunc_held_ready", s_tready, 0);
        flush = 1;
        repeat (2) @(negedge clk);

        // 4: random backpressure and source gaps, same packet as test 2
        gap_mode = 1; rdy_rand = 1;
        clear_cap();
        pl = '{8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt(2'b00, 1'b0, pl);
        wait_done("stall");
        chk("stall_len", cap_q.size(), 7);
        for (int k = 0; k < 7; k++) chk("stall_same_as_t2", cap_q[k], (k < cap2.size()) ? cap2[k] : 8'hXX);
        gap_mode = 0; rdy_rand = 0;
        repeat (3) @(negedge clk);

        // 5: start while busy is ignored; back-to-back DATA1 then DATA0
        clear_cap();
        pl = '{8'hAA, 8'hBB, 8'hCC};
        send_pkt(2'b01, 1'b0, pl);
        chk("busy_during_pkt", busy, 1);
        @(posedge clk); #1; start = 1; data_type = 2'b10; zlp = 0;
        @(posedge clk); #1; start = 0;
        wait_last_fire();
        pl = '{8'h11, 8'h22};
        send_pkt(2'b00, 1'b0, pl);
        wait_done("b2b");
        chk("b2b_len", cap_q.size(), 11);
        chk("b2b_second_pid", (cap_q.size() > 6) ? cap_q[6] : 8'hXX, 8'hC3);

        // 6: reset mid-DATA, then a clean packet
        clear_cap();
        pl = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        send_pkt(2'b00, 1'b0, pl);
        repeat (2) @(negedge clk);
        flush = 1;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_tvalid", tx_tvalid, 0);
        chk("midrst_tlast", tx_tlast, 0);
        chk("midrst_tdata", tx_tdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", {done, truncated}, 0);
        chk("midrst_s_tready", s_tready, 0);
        clear_cap();
        pl = '{8'h5A, 8'hA5};
        send_pkt(2'b10, 1'b0, pl);
        wait_done("post_rst");
        chk("post_rst_len", cap_q.size(), 5);
        chk("post_rst_head", {cap_q[0], cap_q[1], cap_q[2]}, 24'h875AA5);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
